// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Round-robin arbiter that shares the NUM_LANES-wide common data bus among
// NUM_REQ functional-unit result ports. Winners of a cycle are packed into
// consecutive lanes starting at lane 0 and appear on the CDB one cycle after
// their handshake. At most one flush-carrying result is granted per cycle.
// A ROB pipeline flush blocks all grants, clears the lanes and rewinds the
// priority pointer.
//
// Optional build macro:
//   CDB_ARB_STATS_EN - adds the stall_count output, a saturating count of
//                      cycles (outside a pipeline flush) in which at least one
//                      valid requester was left without a grant.
//
// Ports:
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous active-low reset
//   req_valid        in   [NUM_REQ]         per-requester result valid
//   req_index_flat   in   [NUM_REQ*IDX_W]   ROB index, requester r at r*IDX_W
//   req_value_flat   in   [NUM_REQ*DATA_W]  result value, requester r at r*DATA_W
//   req_flush        in   [NUM_REQ]         result is a taken-branch redirect
//   req_ready        out  [NUM_REQ]         grant, combinational
//   flush_pipeline   in   ROB redirect in progress
//   cdb_valid_flat   out  [NUM_LANES]       lane k at bit NUM_LANES-1-k
//   indices_flat     out  [NUM_LANES*IDX_W] same lane ordering
//   values_flat      out  [NUM_LANES*DATA_W] same lane ordering
//   flush_flat       out  [NUM_LANES]       same lane ordering
//   stall_count      out  [16]              only with CDB_ARB_STATS_EN
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_REQ   = 6,
    parameter int NUM_LANES = 4,
    parameter int IDX_W     = 4,
    parameter int DATA_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*IDX_W-1:0]    req_index_flat,
    input  logic [NUM_REQ*DATA_W-1:0]   req_value_flat,
    input  logic [NUM_REQ-1:0]          req_flush,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        flush_pipeline,
    output logic [NUM_LANES-1:0]        cdb_valid_flat,
    output logic [NUM_LANES*IDX_W-1:0]  indices_flat,
    output logic [NUM_LANES*DATA_W-1:0] values_flat,
    output logic [NUM_LANES-1:0]        flush_flat
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [15:0]                 stall_count
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_LANES-1:0] lane_vld_q, lane_vld_d;
    logic [NUM_LANES-1:0] lane_fl_q, lane_fl_d;
    logic [IDX_W-1:0]     lane_idx_q [NUM_LANES];
    logic [IDX_W-1:0]     lane_idx_d [NUM_LANES];
    logic [DATA_W-1:0]    lane_val_q [NUM_LANES];
    logic [DATA_W-1:0]    lane_val_d [NUM_LANES];

    // Scan requesters starting at rr_ptr; each grant takes the next free lane.
    // A second flush-carrying requester is passed over, but the scan goes on
    // so later non-flush requesters can still fill the remaining lanes.
    always_comb begin : arbitrate
        int   r;
        int   n_grant;
        logic flush_taken;
        grant       = '0;
        rr_ptr_d    = rr_ptr_q;
        lane_vld_d  = '0;
        lane_fl_d   = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_idx_d[k] = '0;
            lane_val_d[k] = '0;
        end
        r           = 0;
        n_grant     = 0;
        flush_taken = 1'b0;
        if (rst_n && !flush_pipeline) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r = int'(rr_ptr_q) + i;
                if (r >= NUM_REQ) r = r - NUM_REQ;
                if (req_valid[r] && (n_grant < NUM_LANES) &&
                    !(req_flush[r] && flush_taken)) begin
                    grant[r]            = 1'b1;
                    lane_vld_d[n_grant] = 1'b1;
                    lane_fl_d[n_grant]  = req_flush[r];
                    lane_idx_d[n_grant] = req_index_flat[r*IDX_W +: IDX_W];
                    lane_val_d[n_grant] = req_value_flat[r*DATA_W +: DATA_W];
                    flush_taken         = flush_taken | req_flush[r];
                    n_grant             = n_grant + 1;
                    // Pointer ends one past the last winner.
                    rr_ptr_d = (r == NUM_REQ - 1) ? '0 : PTR_W'(r + 1);
                end
            end
        end
    end

    assign req_ready = grant;

    // Lane registers hold a transfer for exactly one cycle. A pipeline flush
    // clears them and rewinds the pointer regardless of the grant logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            lane_vld_q <= '0;
            lane_fl_q  <= '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                lane_idx_q[k] <= '0;
                lane_val_q[k] <= '0;
            end
        end else if (flush_pipeline) begin
            rr_ptr_q   <= '0;
            lane_vld_q <= '0;
            lane_fl_q  <= '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                lane_idx_q[k] <= '0;
                lane_val_q[k] <= '0;
            end
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lane_vld_q <= lane_vld_d;
            lane_fl_q  <= lane_fl_d;
            for (int k = 0; k < NUM_LANES; k++) begin
                lane_idx_q[k] <= lane_idx_d[k];
                lane_val_q[k] <= lane_val_d[k];
            end
        end
    end

    // Lane 0 sits in the most significant slot of each flat bus.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign cdb_valid_flat[NUM_LANES-1-k]                 = lane_vld_q[k];
        assign flush_flat[NUM_LANES-1-k]                     = lane_fl_q[k];
        assign indices_flat[(NUM_LANES-1-k)*IDX_W +: IDX_W]  = lane_idx_q[k];
        assign values_flat[(NUM_LANES-1-k)*DATA_W +: DATA_W] = lane_val_q[k];
    end

`ifdef CDB_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_cycle;

    assign stall_cycle = !flush_pipeline && (|(req_valid & ~grant));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cycle && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int NR = 6;
    localparam int NL = 4;
    localparam int IW = 4;
    localparam int DW = 16;

    typedef struct packed {
        logic [NL-1:0]    vld;
        logic [NL*IW-1:0] idx;
        logic [NL*DW-1:0] val;
        logic [NL-1:0]    fl;
    } lanes_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*IW-1:0]  req_index_flat;
    logic [NR*DW-1:0]  req_value_flat;
    logic [NR-1:0]     req_flush;
    logic [NR-1:0]     req_ready;
    logic              flush_pipeline;
    logic [NL-1:0]     cdb_valid_flat;
    logic [NL*IW-1:0]  indices_flat;
    logic [NL*DW-1:0]  values_flat;
    logic [NL-1:0]     flush_flat;
`ifdef CDB_ARB_STATS_EN
    logic [15:0]       stall_count;
`endif

    logic [IW-1:0] idx_a [NR];
    logic [DW-1:0] val_a [NR];
    lanes_t        exp_q [$];
    int            checks = 0;
    int            errors = 0;

    cdb_arbiter #(.NUM_REQ(NR), .NUM_LANES(NL), .IDX_W(IW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_index_flat (req_index_flat),
        .req_value_flat (req_value_flat),
        .req_flush      (req_flush),
        .req_ready      (req_ready),
        .flush_pipeline (flush_pipeline),
        .cdb_valid_flat (cdb_valid_flat),
        .indices_flat   (indices_flat),
        .values_flat    (values_flat),
        .flush_flat     (flush_flat)
`ifdef CDB_ARB_STATS_EN
        ,
        .stall_count    (stall_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0] f);
        req_valid = v;
        req_flush = f;
        for (int r = 0; r < NR; r++) begin
            req_index_flat[r*IW +: IW] = idx_a[r];
            req_value_flat[r*DW +: DW] = val_a[r];
        end
    endtask

    task automatic default_data();
        for (int r = 0; r < NR; r++) begin
            idx_a[r] = IW'(8 + r);
            val_a[r] = DW'(16'hA000 + r * 16'h0111);
        end
    endtask

    // Expected lane contents for requesters listed in lane order (-1 = unused),
    // taken from the stimulus currently applied.
    function automatic lanes_t mk(input int l0, input int l1, input int l2, input int l3);
        lanes_t e;
        int     l [4];
        e = '0;
        l[0] = l0; l[1] = l1; l[2] = l2; l[3] = l3;
        for (int k = 0; k < NL; k++) begin
            if (l[k] >= 0) begin
                e.vld[NL-1-k]            = 1'b1;
                e.fl[NL-1-k]             = req_flush[l[k]];
                e.idx[(NL-1-k)*IW +: IW] = idx_a[l[k]];
                e.val[(NL-1-k)*DW +: DW] = val_a[l[k]];
            end
        end
        return e;
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        flush_pipeline = 1'b0;
        default_data();
        drive('0, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        lanes_t got;
        rst_n = 1'b0;
        flush_pipeline = 1'b0;
        default_data();
        drive('1, '0);
        repeat (2) @(negedge clk);
        got = {cdb_valid_flat, indices_flat, values_flat, flush_flat};
        checks++;
        if (got !== '0) begin
            errors++; $display("FAIL reset_lanes got=%h exp=0", got);
        end
        checks++;
        if (req_ready !== '0) begin
            errors++; $display("FAIL reset_ready got=%b exp=0", req_ready);
        end
        drive('0, '0);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        lanes_t e, got;
        logic [NR-1:0] er;
        idx_a[0] = 4'h3;
        val_a[0] = 16'hBEEF;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) begin drive(6'b000001, '0); er = 6'b000001; e = mk(0, -1, -1, -1); end
            else        begin drive('0, '0);       er = '0;         e = mk(-1, -1, -1, -1); end
            #1;
            checks++;
            if (req_ready !== er) begin
                errors++; $display("FAIL single_ready[%0d] got=%b exp=%b", c, req_ready, er);
            end
            exp_q.push_back(e);
            @(posedge clk); @(negedge clk);
            got = {cdb_valid_flat, indices_flat, values_flat, flush_flat};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL single_lanes[%0d] got=%h exp=%h", c, got, e);
            end
        end
    endtask

    task automatic test_round_robin();
        lanes_t e, got;
        logic [NR-1:0] er;
        reset_dut();
        for (int c = 0; c < 4; c++) begin
            case (c)
                0:       begin drive('1, '0); er = 6'b001111; e = mk(0, 1, 2, 3); end
                1:       begin drive('1, '0); er = 6'b110011; e = mk(4, 5, 0, 1); end
                2:       begin drive('1, '0); er = 6'b111100; e = mk(2, 3, 4, 5); end
                default: begin drive('0, '0); er = '0;        e = mk(-1, -1, -1, -1); end
            endcase
            #1;
            checks++;
            if (req_ready !== er) begin
                errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", c, req_ready, er);
            end
            exp_q.push_back(e);
            @(posedge clk); @(negedge clk);
            got = {cdb_valid_flat, indices_flat, values_flat, flush_flat};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL rr_lanes[%0d] got=%h exp=%h", c, got, e);
            end
        end
    endtask

    task automatic test_flush_conflict();
        lanes_t e, got;
        logic [NR-1:0] er;
        reset_dut();
        for (int c = 0; c < 3; c++) begin
            case (c)
                0:       begin drive(6'b001110, 6'b000110); er = 6'b001010; e = mk(1, 3, -1, -1); end
                1:       begin drive(6'b000100, 6'b000100); er = 6'b000100; e = mk(2, -1, -1, -1); end
                default: begin drive('0, '0);               er = '0;        e = mk(-1, -1, -1, -1); end
            endcase
            #1;
            checks++;
            if (req_ready !== er) begin
                errors++; $display("FAIL fconf_ready[%0d] got=%b exp=%b", c, req_ready, er);
            end
            exp_q.push_back(e);
            @(posedge clk); @(negedge clk);
            got = {cdb_valid_flat, indices_flat, values_flat, flush_flat};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL fconf_lanes[%0d] got=%h exp=%h", c, got, e);
            end
        end
    endtask

    task automatic test_pipeline_flush();
        lanes_t e, got;
        logic [NR-1:0] er;
        reset_dut();
        for (int c = 0; c < 3; c++) begin
            flush_pipeline = (c == 1);
            case (c)
                0:       begin drive(6'b000100, '0); er = 6'b000100; e = mk(2, -1, -1, -1); end
                1:       begin drive(6'b001111, '0); er = '0;        e = mk(-1, -1, -1, -1); end
                default: begin drive(6'b001111, '0); er = 6'b001111; e = mk(0, 1, 2, 3); end
            endcase
            #1;
            checks++;
            if (req_ready !== er) begin
                errors++; $display("FAIL pflush_ready[%0d] got=%b exp=%b", c, req_ready, er);
            end
            exp_q.push_back(e);
            @(posedge clk); @(negedge clk);
            got = {cdb_valid_flat, indices_flat, values_flat, flush_flat};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL pflush_lanes[%0d] got=%h exp=%h", c, got, e);
            end
        end
        flush_pipeline = 1'b0;
        drive('0, '0);
    endtask

    task automatic test_async_reset();
        lanes_t e, got;
        reset_dut();
        drive(6'b111111, '0);
        exp_q.push_back(mk(0, 1, 2, 3));
        @(posedge clk); @(negedge clk);
        got = {cdb_valid_flat, indices_flat, values_flat, flush_flat};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++; $display("FAIL areset_pre got=%h exp=%h", got, e);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {cdb_valid_flat, indices_flat, values_flat, flush_flat};
        checks++;
        if (got !== '0) begin
            errors++; $display("FAIL areset_lanes got=%h exp=0", got);
        end
        checks++;
        if (req_ready !== '0) begin
            errors++; $display("FAIL areset_ready got=%b exp=0", req_ready);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 6'b001111) begin
            errors++; $display("FAIL arelease_ready got=%b exp=001111", req_ready);
        end
        exp_q.push_back(mk(0, 1, 2, 3));
        @(posedge clk); @(negedge clk);
        got = {cdb_valid_flat, indices_flat, values_flat, flush_flat};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++; $display("FAIL arelease_lanes got=%h exp=%h", got, e);
        end
        drive('0, '0);
    endtask

    task automatic test_back_to_back();
        lanes_t e, got;
        logic [NR-1:0] er;
        reset_dut();
        for (int c = 0; c < 5; c++) begin
            if (c < 4) begin
                idx_a[0] = IW'(c);
                val_a[0] = DW'(16'h1111 * (c + 1));
                drive(6'b000001, {5'b0, c[0]});
                er = 6'b000001;
                e  = mk(0, -1, -1, -1);
            end else begin
                drive('0, '0);
                er = '0;
                e  = mk(-1, -1, -1, -1);
            end
            #1;
            checks++;
            if (req_ready !== er) begin
                errors++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", c, req_ready, er);
            end
            exp_q.push_back(e);
            @(posedge clk); @(negedge clk);
            got = {cdb_valid_flat, indices_flat, values_flat, flush_flat};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL b2b_lanes[%0d] got=%h exp=%h", c, got, e);
            end
        end
    endtask

    task automatic test_dup_index();
        lanes_t e, got;
        reset_dut();
        idx_a[4] = 4'h5;
        idx_a[5] = 4'h5;
        drive(6'b110000, '0);
        #1;
        checks++;
        if (req_ready !== 6'b110000) begin
            errors++; $display("FAIL dup_ready got=%b exp=110000", req_ready);
        end
        exp_q.push_back(mk(4, 5, -1, -1));
        @(posedge clk); @(negedge clk);
        got = {cdb_valid_flat, indices_flat, values_flat, flush_flat};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++; $display("FAIL dup_lanes got=%h exp=%h", got, e);
        end
        drive('0, '0);
    endtask

`ifdef CDB_ARB_STATS_EN
    task automatic test_stats();
        reset_dut();
        drive('1, '0);
        repeat (10) @(negedge clk);
        checks++;
        if (stall_count !== 16'd10) begin
            errors++; $display("FAIL stall_10 got=%0d exp=10", stall_count);
        end
        flush_pipeline = 1'b1;
        repeat (2) @(negedge clk);
        flush_pipeline = 1'b0;
        checks++;
        if (stall_count !== 16'd10) begin
            errors++; $display("FAIL stall_flush got=%0d exp=10", stall_count);
        end
        repeat (65524) @(negedge clk);
        checks++;
        if (stall_count !== 16'hFFFE) begin
            errors++; $display("FAIL stall_fffe got=%h exp=fffe", stall_count);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (stall_count !== 16'hFFFF) begin
            errors++; $display("FAIL stall_sat got=%h exp=ffff", stall_count);
        end
        drive('0, '0);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_flush_conflict();
        test_pipeline_flush();
        test_async_reset();
        test_back_to_back();
        test_dup_index();
`ifdef CDB_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
